// File: rtl/count_sequencer.sv
// Command sequencer for a WIDTH-bit up/down counter: turns LOAD / count commands into
// preload, direction and count-enable strobes, and reports completion and overflow.
//
// state | meaning
// IDLE  | ready for a command (cmd_ready high)
// LOAD  | _load strobe low for one cycle with preld_val driven
// RUN   | carry_in high; counting remaining down or waiting for overflow
// DONE  | one-cycle done pulse; cnt_value captured into last_value
module count_sequencer #(
   parameter int unsigned WIDTH       = 16,
   parameter bit          WRAP        = 1'b1,
   parameter bit          STOP_ON_OVF = 1'b1
) (
   input  logic             clk,
   input  logic             _sreset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_value,
   input  logic             cnt_overflow,
   output logic             _load,
   output logic [WIDTH-1:0] preld_val,
   output logic             _updown,
   output logic             _wrapstop,
   output logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic             err_ovf,
   output logic [WIDTH-1:0] last_value
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [1:0] OP_LOAD      = 2'b00;
   localparam logic [1:0] OP_UP_N      = 2'b01;
   localparam logic [1:0] OP_DOWN_N    = 2'b10;
   localparam logic [1:0] OP_UP_TO_OVF = 2'b11;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             load_n_q, load_n_d;
   logic [WIDTH-1:0] preld_q, preld_d;
   logic             updown_q, updown_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             stop;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      remaining_d = remaining_q;
      load_n_d    = 1'b1;
      preld_d     = preld_q;
      updown_d    = updown_q;
      carry_d     = 1'b0;
      err_d       = err_q;
      last_d      = last_q;
      stop        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d  = cmd_op;
               err_d = 1'b0;
               case (cmd_op)
                  OP_LOAD: begin
                     state_d  = ST_LOAD;
                     load_n_d = 1'b0;
                     preld_d  = cmd_data;
                  end
                  OP_UP_N, OP_DOWN_N: begin
                     remaining_d = cmd_data;
                     updown_d    = (cmd_op == OP_UP_N);
                     if (cmd_data == '0) begin
                        state_d = ST_DONE;
                     end else begin
                        state_d = ST_RUN;
                        carry_d = 1'b1;
                     end
                  end
                  default: begin
                     remaining_d = '0;
                     updown_d    = 1'b1;
                     state_d     = ST_RUN;
                     carry_d     = 1'b1;
                  end
               endcase
            end
         end
         ST_LOAD: begin
            state_d = ST_DONE;
         end
         ST_RUN: begin
            carry_d = 1'b1;
            if (op_q == OP_UP_TO_OVF) begin
               stop = cnt_overflow;
            end else begin
               remaining_d = remaining_q - WIDTH'(1);
               if (cnt_overflow) begin
                  err_d = 1'b1;
                  if (STOP_ON_OVF) stop = 1'b1;
               end
               if (remaining_q == WIDTH'(1)) stop = 1'b1;
            end
            if (abort) stop = 1'b1;
            if (stop) begin
               state_d     = ST_DONE;
               carry_d     = 1'b0;
               remaining_d = '0;
            end
         end
         default: begin
            last_d  = cnt_value;
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered copies of the next state so they line up with it.
      done_d      = (state_d == ST_DONE);
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!_sreset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LOAD;
         remaining_q <= '0;
         cmd_ready_q <= 1'b1;
         load_n_q    <= 1'b1;
         preld_q     <= '0;
         updown_q    <= 1'b1;
         carry_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         last_q      <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         remaining_q <= remaining_d;
         cmd_ready_q <= cmd_ready_d;
         load_n_q    <= load_n_d;
         preld_q     <= preld_d;
         updown_q    <= updown_d;
         carry_q     <= carry_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         last_q      <= last_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign _load      = load_n_q;
   assign preld_val  = preld_q;
   assign _updown    = updown_q;
   assign _wrapstop  = WRAP;
   assign carry_in   = carry_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err_ovf    = err_q;
   assign last_value = last_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a behavioural 16-bit wrapping counter closes the loop and
// per-command outcomes are predicted arithmetically from start value, n and abort point.
module tb_count_sequencer;

   logic        clk = 1'b0;
   logic        _sreset;
   logic        cmd_valid, cmd_ready, abort;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_data, cnt_value, preld_val, last_value;
   logic        cnt_overflow, _load, _updown, _wrapstop, carry_in, busy, done, err_ovf;

   int errors = 0;
   int checks = 0;
   logic [15:0] ref_val = 16'h0000;

   always #5 clk = ~clk;

   count_sequencer dut (
      .clk(clk), ._sreset(_sreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .cnt_value(cnt_value),
      .cnt_overflow(cnt_overflow), ._load(_load), .preld_val(preld_val), ._updown(_updown),
      ._wrapstop(_wrapstop), .carry_in(carry_in), .busy(busy), .done(done),
      .err_ovf(err_ovf), .last_value(last_value)
   );

   // Environment: the counter being controlled; overflow flags the cycle after a wrap.
   logic [15:0] cnt_q = 16'h0000;
   logic        ovf_q = 1'b0;
   assign cnt_value    = cnt_q;
   assign cnt_overflow = ovf_q;
   always @(posedge clk) begin
      if (_load === 1'b0) begin
         cnt_q <= preld_val;
         ovf_q <= 1'b0;
      end else if (carry_in === 1'b1) begin
         if (_updown) begin
            cnt_q <= cnt_q + 16'd1;
            ovf_q <= (cnt_q == 16'hFFFF);
         end else begin
            cnt_q <= cnt_q - 16'd1;
            ovf_q <= (cnt_q == 16'h0000);
         end
      end else begin
         ovf_q <= 1'b0;
      end
   end

   // Expected enables, overflow error, final counter value and done latency of a command.
   function automatic void model(input logic [1:0] op, input logic [15:0] v, input logic [15:0] d,
                                 input int ab, output int en, output bit err,
                                 output logic [15:0] fin, output int dc);
      int m;
      en  = 0;
      err = 1'b0;
      if (op == 2'b00) begin
         fin = d;
         dc  = 2;
         return;
      end
      m = (op == 2'b10) ? int'(v) + 1 : 65536 - int'(v);
      if (op == 2'b11)          en = m + 1;
      else if (d == 16'd0)      en = 0;
      else if (m < int'(d)) begin
         en  = m + 1;
         err = 1'b1;
      end else                  en = int'(d);
      if (ab != 0 && ab < en) begin
         en  = ab;
         err = 1'b0;
      end
      fin = (op == 2'b10) ? v - 16'(en) : v + 16'(en);
      dc  = en + 1;
   endfunction

   // Issue one command from a negedge and observe it until the done cycle (returns at that negedge).
   task automatic run_cmd(input logic [1:0] op, input logic [15:0] data, input int abort_at,
                          input bit abort_all, input bit hold,
                          output int en_cnt, output int load_cnt, output logic [15:0] preld_seen,
                          output logic ud_seen, output int done_cyc, output int last_en,
                          output bit consec, output logic err_at_done, output bit tmo);
      int  cyc;
      int  w;
      bit  seen_done;
      bit  prev_c;
      en_cnt = 0; load_cnt = 0; preld_seen = 16'h0; ud_seen = 1'b0; done_cyc = 0;
      last_en = 0; consec = 1'b1; err_at_done = 1'b0; tmo = 1'b0;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      abort     = abort_all;
      cyc = 0; seen_done = 1'b0; prev_c = 1'b0;
      while (!seen_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (!hold) cmd_valid = 1'b0;
         if (carry_in === 1'b1) begin
            en_cnt++;
            last_en = cyc;
            if (en_cnt > 1 && !prev_c) consec = 1'b0;
         end
         prev_c = (carry_in === 1'b1);
         if (_load === 1'b0) begin
            load_cnt++;
            preld_seen = preld_val;
         end
         if (done === 1'b1) begin
            seen_done   = 1'b1;
            done_cyc    = cyc;
            err_at_done = err_ovf;
            ud_seen     = _updown;
         end
         abort = abort_all || (abort_at != 0 && carry_in === 1'b1 && en_cnt == abort_at);
      end
      abort = 1'b0;
      if (!seen_done) tmo = 1'b1;
   endtask

   int          en, lc, dc, le, x_en, x_dc;
   logic [15:0] pv, x_fin;
   logic        ud, ed;
   bit          cs, to, x_err;

   task automatic test_reset;
      _sreset = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_op = 2'b00; cmd_data = 16'h0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, _load, _updown, carry_in, busy, done, err_ovf} !== 7'b1110000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 1110000",
                  {cmd_ready, _load, _updown, carry_in, busy, done, err_ovf});
      end
      checks++;
      if (preld_val !== 16'h0 || last_value !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: preld=%h last=%h expected 0000/0000", preld_val, last_value);
      end
      checks++;
      if (_wrapstop !== 1'b1) begin
         errors++;
         $display("FAIL wrapstop: got %b expected 1", _wrapstop);
      end
      _sreset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load;
      // abort held high throughout must have no effect on a LOAD
      run_cmd(2'b00, 16'h00F0, 0, 1'b1, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      checks++;
      if (to || lc != 1 || pv !== 16'h00F0) begin
         errors++;
         $display("FAIL load_strobe: load_cycles=%0d preld=%h tmo=%0d expected 1/00f0/0", lc, pv, to);
      end
      checks++;
      if (dc != 2 || en != 0) begin
         errors++;
         $display("FAIL load_done: done_cycle=%0d enables=%0d expected 2/0", dc, en);
      end
      @(negedge clk);
      checks++;
      if (last_value !== 16'h00F0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_last: last=%h busy=%b ready=%b expected 00f0/0/1", last_value, busy, cmd_ready);
      end
      ref_val = 16'h00F0;
   endtask

   task automatic test_down_n;
      run_cmd(2'b00, 16'h0005, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      @(negedge clk);
      run_cmd(2'b10, 16'd3, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      checks++;
      if (to || en != 3 || !cs || ud !== 1'b0) begin
         errors++;
         $display("FAIL down_enables: enables=%0d consec=%0d updown=%b expected 3/1/0", en, cs, ud);
      end
      checks++;
      if (dc != 4 || le != 3) begin
         errors++;
         $display("FAIL down_done: done_cycle=%0d last_enable=%0d expected 4/3", dc, le);
      end
      @(negedge clk);
      checks++;
      if (last_value !== 16'h0002) begin
         errors++;
         $display("FAIL down_last: got %h expected 0002", last_value);
      end
      ref_val = 16'h0002;
   endtask

   task automatic test_ovf_stop;
      run_cmd(2'b00, 16'hFFFE, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      @(negedge clk);
      model(2'b01, 16'hFFFE, 16'd5, 0, x_en, x_err, x_fin, x_dc);
      run_cmd(2'b01, 16'd5, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      checks++;
      if (to || en != x_en || dc != x_dc || ed !== x_err || ed !== 1'b1) begin
         errors++;
         $display("FAIL ovf_stop: enables=%0d done=%0d err=%b expected %0d/%0d/1", en, dc, ed, x_en, x_dc);
      end
      @(negedge clk);
      checks++;
      if (err_ovf !== 1'b1 || last_value !== x_fin) begin
         errors++;
         $display("FAIL ovf_sticky: err=%b last=%h expected 1/%h", err_ovf, last_value, x_fin);
      end
      run_cmd(2'b01, 16'd0, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      checks++;
      if (to || en != 0 || dc != 1 || ed !== 1'b0) begin
         errors++;
         $display("FAIL up_zero: enables=%0d done=%0d err=%b expected 0/1/0", en, dc, ed);
      end
      @(negedge clk);
      ref_val = x_fin;
   endtask

   task automatic test_up_to_ovf;
      run_cmd(2'b00, 16'hFFFC, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      @(negedge clk);
      run_cmd(2'b11, 16'h1234, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      checks++;
      if (to || en != 5 || dc != 6 || le != 5 || !cs || ed !== 1'b0 || ud !== 1'b1) begin
         errors++;
         $display("FAIL up_to_ovf: enables=%0d done=%0d last_en=%0d err=%b ud=%b expected 5/6/5/0/1",
                  en, dc, le, ed, ud);
      end
      @(negedge clk);
      checks++;
      if (last_value !== 16'h0001) begin
         errors++;
         $display("FAIL up_to_ovf_last: got %h expected 0001", last_value);
      end
      ref_val = 16'h0001;
   endtask

   task automatic test_abort_hold;
      int w;
      run_cmd(2'b00, 16'h0000, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      @(negedge clk);
      run_cmd(2'b01, 16'd100, 7, 1'b0, 1'b1, en, lc, pv, ud, dc, le, cs, ed, to);
      checks++;
      if (to || en != 7 || dc != 8 || !cs) begin
         errors++;
         $display("FAIL abort: enables=%0d done=%0d consec=%0d expected 7/8/1", en, dc, cs);
      end
      cmd_op   = 2'b00;
      cmd_data = 16'h1234;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || last_value !== 16'h0007) begin
         errors++;
         $display("FAIL held_idle: ready=%b busy=%b last=%h expected 1/0/0007", cmd_ready, busy, last_value);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (_load !== 1'b0 || preld_val !== 16'h1234 || busy !== 1'b1) begin
         errors++;
         $display("FAIL held_accept: load=%b preld=%h busy=%b expected 0/1234/1", _load, preld_val, busy);
      end
      w = 0;
      while (done !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL held_done: done not seen within 10 cycles");
      end
      @(negedge clk);
      ref_val = 16'h1234;
   endtask

   task automatic test_reset_mid;
      int w;
      run_cmd(2'b00, 16'h0ABC, 0, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 16'd10;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (carry_in !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_run: carry=%b busy=%b expected 1/1", carry_in, busy);
      end
      _sreset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, _load, _updown, carry_in, busy, done, err_ovf} !== 7'b1110000 ||
          preld_val !== 16'h0 || last_value !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset: flags=%b preld=%h last=%h expected 1110000/0000/0000",
                  {cmd_ready, _load, _updown, carry_in, busy, done, err_ovf}, preld_val, last_value);
      end
      _sreset = 1'b1;
      w = 0;
      repeat (3) begin
         @(negedge clk);
         if (carry_in !== 1'b0 || busy !== 1'b0) w++;
      end
      checks++;
      if (w != 0) begin
         errors++;
         $display("FAIL post_reset_idle: %0d active cycles expected 0", w);
      end
   endtask

   task automatic test_random;
      logic [1:0]  op;
      logic [15:0] d;
      int          ab;
      for (int i = 0; i < 30; i++) begin
         op = (i == 0) ? 2'b00 : 2'($urandom_range(0, 3));
         if (op == 2'b11 && ref_val < 16'hFFC0) op = 2'b00;
         if (op == 2'b00) begin
            case ($urandom_range(0, 2))
               0:       d = 16'hFFC0 + 16'($urandom_range(0, 63));
               1:       d = 16'($urandom_range(0, 40));
               default: d = 16'($urandom);
            endcase
         end else begin
            d = 16'($urandom_range(0, 40));
         end
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
         model(op, ref_val, d, ab, x_en, x_err, x_fin, x_dc);
         run_cmd(op, d, ab, 1'b0, 1'b0, en, lc, pv, ud, dc, le, cs, ed, to);
         checks++;
         if (to || en != x_en || dc != x_dc || ed !== x_err || !cs) begin
            errors++;
            $display("FAIL rand_cmd[%0d] op=%0d d=%h start=%h ab=%0d: en=%0d dc=%0d err=%b tmo=%0d expected %0d/%0d/%b",
                     i, op, d, ref_val, ab, en, dc, ed, to, x_en, x_dc, x_err);
         end
         @(negedge clk);
         checks++;
         if (last_value !== x_fin) begin
            errors++;
            $display("FAIL rand_last[%0d]: got %h expected %h", i, last_value, x_fin);
         end
         ref_val = x_fin;
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_down_n();
      test_ovf_stop();
      test_up_to_ovf();
      test_abort_hold();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
